// File: rtl/div_pkg.sv
// div_pkg: divider ratios, channel indices and checker state encoding shared by
// the clock-divider consumer-side checker.
package div_pkg;
    localparam int HALF4_DEF = 2;
    localparam int HALF8_DEF = 4;
    localparam int HALF80_DEF = 40;
    localparam int CH4 = 0;
    localparam int CH8 = 1;
    localparam int CH80 = 2;
    localparam int PH = 3;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;
endpackage

// File: rtl/half_period_chk.sv
// half_period_chk: measures the half-period of one divided signal and tracks lock.
// err_o only fires for errors seen while locked; earlier errors just restart acquisition.
module half_period_chk
    import div_pkg::*;
#(
    parameter int HALF = HALF4_DEF,
    parameter int LOCK_CNT = 4,
    parameter int CW = $clog2(HALF80_DEF + 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic lock_o,
    output logic edge_o,
    output logic rise_o,
    output logic err_o
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] SAT_C = CW'(HALF + 1);

    chk_state_e state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic hist_q, good_edge, bad;

    assign edge_o = sig_i ^ hist_q;
    assign rise_o = sig_i & ~hist_q;
    assign good_edge = edge_o && cnt_q == HALF_C;
    // an edge landing on the saturated count is neither good nor a fresh error
    assign bad = state_q != ST_IDLE && (edge_o ? cnt_q < HALF_C : cnt_q == HALF_C);
    assign cnt_d = edge_o ? CW'(1) : (cnt_q == '0 || cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hist_q <= sig_i;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            good_q <= '0;
        end else begin
            state_q <= state_d;
            good_q <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d = good_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_o) begin
                    state_d = ST_TRACK;
                    good_d = '0;
                end
            end
            ST_TRACK: begin
                if (bad) begin
                    good_d = '0;
                end else if (good_edge) begin
                    good_d = good_q + 1'b1;
                    state_d = good_q == GW'(LOCK_CNT - 1) ? ST_LOCKED : ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (bad) begin
                    state_d = ST_TRACK;
                    good_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lock_o = state_q == ST_LOCKED;
        err_o = lock_o && bad;
    end
endmodule

// File: rtl/div_ratio_checker.sv
// div_ratio_checker: monitors the div4/div8/div80 enables from the clock divider,
// reporting lock, sticky errors, an error pulse and a saturating error count.
module div_ratio_checker
    import div_pkg::*;
#(
    parameter int HALF4 = HALF4_DEF,
    parameter int HALF8 = HALF8_DEF,
    parameter int HALF80 = HALF80_DEF,
    parameter int LOCK_CNT = 4,
    parameter int ERRW = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic div4_i,
    input  logic div8_i,
    input  logic div80_i,
    input  logic clr_i,
    output logic locked_o,
    output logic [2:0] lock_o,
    output logic [3:0] err_sticky_o,
    output logic err_pulse_o,
    output logic [ERRW-1:0] err_count_o
);
    localparam int CW = $clog2(HALF80 + 2);

    logic [2:0] edge_w, rise_w, err_w;
    logic [3:0] ev, sticky_q, sticky_d;
    logic [2:0] ev_n;
    logic [ERRW:0] sum;
    logic [ERRW-1:0] count_q, count_d;
    logic pulse_q, unused_taps;

    half_period_chk #(.HALF(HALF4), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_ch4 (
        .clk(clk), .reset(reset), .sig_i(div4_i), .lock_o(lock_o[CH4]),
        .edge_o(edge_w[CH4]), .rise_o(rise_w[CH4]), .err_o(err_w[CH4])
    );
    half_period_chk #(.HALF(HALF8), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_ch8 (
        .clk(clk), .reset(reset), .sig_i(div8_i), .lock_o(lock_o[CH8]),
        .edge_o(edge_w[CH8]), .rise_o(rise_w[CH8]), .err_o(err_w[CH8])
    );
    half_period_chk #(.HALF(HALF80), .LOCK_CNT(LOCK_CNT), .CW(CW)) u_ch80 (
        .clk(clk), .reset(reset), .sig_i(div80_i), .lock_o(lock_o[CH80]),
        .edge_o(edge_w[CH80]), .rise_o(rise_w[CH80]), .err_o(err_w[CH80])
    );

    assign unused_taps = &{rise_w[CH80], rise_w[CH8], edge_w[CH80], edge_w[CH4]};
    // div8 must only ever toggle together with a div4 rising edge
    assign ev[PH] = lock_o[CH4] & lock_o[CH8] & edge_w[CH8] & ~rise_w[CH4];
    assign ev[2:0] = err_w;
    assign ev_n = {2'b00, ev[0]} + {2'b00, ev[1]} + {2'b00, ev[2]} + {2'b00, ev[3]};
    assign sum = (clr_i ? '0 : {1'b0, count_q}) + {{(ERRW - 2){1'b0}}, ev_n};
    assign count_d = sum[ERRW] ? '1 : sum[ERRW-1:0];
    assign sticky_d = (clr_i ? 4'b0000 : sticky_q) | ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            count_q <= count_d;
            pulse_q <= |ev;
        end
    end

    assign locked_o = &lock_o;
    assign err_sticky_o = sticky_q;
    assign err_pulse_o = pulse_q;
    assign err_count_o = count_q;
endmodule

// File: tb/tb_div_ratio_checker.sv
// tb_div_ratio_checker: drives an ideal divider with injectable faults and checks
// the checker against scoreboarded expectations.
module tb_div_ratio_checker;
    logic clk = 1'b0;
    logic reset, div4_i, div8_i, div80_i, clr_i;
    logic locked_o, err_pulse_o;
    logic [2:0] lock_o;
    logic [3:0] err_sticky_o;
    logic [7:0] err_count_o;

    always #5 clk = ~clk;

    div_ratio_checker dut (
        .clk(clk), .reset(reset), .div4_i(div4_i), .div8_i(div8_i), .div80_i(div80_i),
        .clr_i(clr_i), .locked_o(locked_o), .lock_o(lock_o), .err_sticky_o(err_sticky_o),
        .err_pulse_o(err_pulse_o), .err_count_o(err_count_o)
    );

    typedef struct {
        string tag;
        int val;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int c = 0, o8 = 0, o80 = 0, pulse_n = 0, pulse_at = -1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    // ideal divider: div8 toggles on div4 rising edges; o8/o80 slip or skip counts
    task automatic tick();
        int v8;
        v8 = c + o8;
        div4_i = ~c[1];
        div8_i = v8[2];
        div80_i = ((c + o80) % 80) >= 40;
        @(posedge clk);
        #1;
        if (err_pulse_o) begin
            pulse_n++;
            pulse_at = c;
        end
        c++;
    endtask

    task automatic wait_lock(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            tick();
            if (lock_o == 3'b111) at = c - 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_i = 1'b0;
        sb_push("rst_outputs", 0);
        tick();
        sb_check({locked_o, lock_o, err_sticky_o, err_pulse_o, err_count_o});
        tick();
        tick();
        reset = 1'b0;
        c = 0;
        o8 = 0;
        o80 = 0;
        pulse_n = 0;
        pulse_at = -1;
    endtask

    initial begin
        int at, mx, lk, st, ct, lost;
        reset = 1'b1;
        clr_i = 1'b0;
        div4_i = 1'b0;
        div8_i = 1'b0;
        div80_i = 1'b0;
        // ideal divider: lock after the 5th div80 edge, then no errors
        do_reset();
        sb_push("a_lock_at", 200);
        wait_lock(400, at);
        sb_check(at);
        sb_push("a_pulses", 0);
        sb_push("a_max_count", 0);
        sb_push("a_lost", 0);
        pulse_n = 0;
        mx = 0;
        lost = 0;
        repeat (2000) begin
            tick();
            if (int'(err_count_o) > mx) mx = int'(err_count_o);
            if (!locked_o) lost = 1;
        end
        sb_check(pulse_n);
        sb_check(mx);
        sb_check(lost);
        // div8 held high two extra cycles: long error at the 4th high cycle
        do_reset();
        sb_push("b_lock_at", 200);
        wait_lock(400, at);
        sb_check(at);
        while (c < 208) tick();
        sb_push("b_pulse_at", 208);
        sb_push("b_lock", 5);
        sb_push("b_sticky", 2);
        sb_push("b_count", 1);
        sb_push("b_relock_at", 226);
        sb_push("b_pulses", 1);
        pulse_n = 0;
        o8 = -1;
        tick();
        lk = lock_o;
        st = err_sticky_o;
        ct = err_count_o;
        o8 = -2;
        tick();
        wait_lock(100, at);
        sb_check(pulse_at);
        sb_check(lk);
        sb_check(st);
        sb_check(ct);
        sb_check(at);
        sb_check(pulse_n);
        // div8 now on div4 falling edges: clr in the same cycle as a phase error
        sb_push("e_sticky", 8);
        sb_push("e_count", 1);
        sb_push("e_pulse", 1);
        sb_push("e_clr_sticky", 0);
        sb_push("e_clr_count", 0);
        while (c < 230) tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        sb_check(err_sticky_o);
        sb_check(err_count_o);
        sb_check(err_pulse_o);
        while (c < 232) tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        sb_check(err_sticky_o);
        sb_check(err_count_o);
        // one div80 half-period of 39: short error, then 160 clk to relock
        do_reset();
        sb_push("c_lock_at", 200);
        sb_push("c_pulse_at", 239);
        sb_push("c_sticky", 4);
        sb_push("c_count", 1);
        sb_push("c_locked", 0);
        sb_push("c_relock_at", 399);
        sb_push("c_pulses", 1);
        wait_lock(400, at);
        sb_check(at);
        while (c < 220) tick();
        o80 = 1;
        pulse_n = 0;
        while (c < 240) tick();
        sb_check(pulse_at);
        sb_check(err_sticky_o);
        sb_check(err_count_o);
        sb_check(locked_o);
        wait_lock(200, at);
        sb_check(at);
        sb_check(pulse_n);
        // div8 one clk early from reset: every div8 edge after tick 20 is a phase error
        do_reset();
        o8 = 1;
        sb_push("d_lock_at", 200);
        sb_push("d_count_at_lock", 45);
        sb_push("d_count", 55);
        sb_push("d_pulses", 10);
        sb_push("d_sticky", 8);
        sb_push("d_lost", 0);
        sb_push("d_count_254", 254);
        sb_push("d_count_255", 255);
        sb_push("d_count_sat", 255);
        wait_lock(400, at);
        sb_check(at);
        sb_check(err_count_o);
        pulse_n = 0;
        lost = 0;
        repeat (40) begin
            tick();
            if (lock_o != 3'b111) lost = 1;
        end
        sb_check(err_count_o);
        sb_check(pulse_n);
        sb_check(err_sticky_o);
        sb_check(lost);
        while (c < 1039) tick();
        sb_check(err_count_o);
        tick();
        tick();
        sb_check(err_count_o);
        while (c < 1101) tick();
        sb_check(err_count_o);
        // reset while locked with errors latched; first post-reset edge stays unchecked
        do_reset();
        sb_push("g_lock_at", 200);
        sb_push("g_count", 0);
        sb_push("g_pulses", 0);
        wait_lock(400, at);
        sb_check(at);
        repeat (100) tick();
        sb_check(err_count_o);
        sb_check(pulse_n);
        chk("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
